// File: rtl/blink_rate_ctrl.sv
// blink_rate_ctrl: button synchroniser, debouncer, rate stepper and tick divider.
// Define BLINK_RATE_PAUSE_EN to build the long-press pause feature.
module blink_rate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int BASE_DIV        = 4,
  parameter int NUM_RATES       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         btn_in,
  output logic                         tick,
  output logic [$clog2(NUM_RATES)-1:0] rate_idx,
  output logic                         btn_pressed,
  output logic                         paused
);

  localparam int RW = $clog2(NUM_RATES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES*4+1);
  localparam int CW = $clog2(BASE_DIV << (NUM_RATES-1));

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES-1);
`ifdef BLINK_RATE_PAUSE_EN
  localparam logic [DW-1:0] LONG_LAST = DW'(4*DEBOUNCE_CYCLES-1);
  localparam logic [DW-1:0] LONG_PRE  = DW'(4*DEBOUNCE_CYCLES-2);
`endif

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  logic          sync1_q, sync2_q;
  logic          btn_s;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          press_d;
  logic [RW-1:0] rate_q;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] last_cnt;
  logic          tick_q, tick_d;
  logic          btn_pressed_q;
  logic          paused_d;
`ifdef BLINK_RATE_PAUSE_EN
  logic          long_d;
  logic          paused_q;
`endif

  // Two-flop synchroniser for the asynchronous raw button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q;

  // Debounce FSM: a level must hold for DEBOUNCE_CYCLES samples to be accepted
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    press_d   = 1'b0;
`ifdef BLINK_RATE_PAUSE_EN
    long_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE_LO: begin
        if (btn_s) begin
          state_d   = WAIT_HI;
          deb_cnt_d = '0;
        end
      end
      WAIT_HI: begin
        if (!btn_s) begin
          state_d = IDLE_LO;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = IDLE_HI;
          press_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      IDLE_HI: begin
        if (!btn_s) begin
          state_d   = WAIT_LO;
          deb_cnt_d = '0;
        end
`ifdef BLINK_RATE_PAUSE_EN
        // Keep timing the hold; toggle pause once, then saturate
        else if (deb_cnt_q != LONG_LAST) begin
          deb_cnt_d = deb_cnt_q + DW'(1);
          long_d    = (deb_cnt_q == LONG_PRE);
        end
`endif
      end
      WAIT_LO: begin
        if (btn_s) begin
          state_d = IDLE_HI;
`ifdef BLINK_RATE_PAUSE_EN
          // Release bounce must not be mistaken for a fresh long hold
          deb_cnt_d = LONG_LAST;
`endif
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = IDLE_LO;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      default: begin
        state_d   = IDLE_LO;
        deb_cnt_d = '0;
      end
    endcase
  end

  // Debounce state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE_LO;
      deb_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

`ifdef BLINK_RATE_PAUSE_EN
  assign paused_d = paused_q ^ long_d;

  // Pause flag flips once per long press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) paused_q <= 1'b0;
    else     paused_q <= paused_d;
  end

  assign paused = paused_q;
`else
  assign paused_d = 1'b0;
  assign paused   = 1'b0;
`endif

  // Terminal count for the current rate: (BASE_DIV << rate) - 1
  assign last_cnt = CW'((BASE_DIV << rate_q) - 1);

  // Divider: a press restarts the period, pause freezes the count
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (press_d) begin
      div_d = '0;
    end else if (!paused_d) begin
      if (div_q == last_cnt) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + CW'(1);
      end
    end
  end

  // Rate index, divider and registered output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_q        <= '0;
      div_q         <= '0;
      tick_q        <= 1'b0;
      btn_pressed_q <= 1'b0;
    end else begin
      if (press_d) rate_q <= rate_q + RW'(1);
      div_q         <= div_d;
      tick_q        <= tick_d;
      btn_pressed_q <= press_d;
    end
  end

  assign tick        = tick_q;
  assign rate_idx    = rate_q;
  assign btn_pressed = btn_pressed_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// tb_blink_rate_ctrl: directed tests for blink_rate_ctrl.
// Pause scenario runs only when BLINK_RATE_PAUSE_EN is defined.
module tb_blink_rate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       tick;
  logic       btn_pressed;
  logic       paused;
  logic [1:0] rate_idx;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  blink_rate_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .tick       (tick),
    .rate_idx   (rate_idx),
    .btn_pressed(btn_pressed),
    .paused     (paused)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_tick();
    int i;
    for (i = 0; i < 80; i++) begin
      step();
      if (tick) break;
    end
    n_chk++;
    if (i == 80) begin
      n_fail++;
      $display("FAIL sync_tick: no tick in 80 cycles, want one");
    end
  endtask

  task automatic test_reset();
    logic et;
    rst = 1'b1;
    btn_in = 1'b0;
    step();
    step();
    n_chk++;
    if ({tick, btn_pressed, paused, rate_idx} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got tick=%b bp=%b p=%b r=%0d want 0",
               tick, btn_pressed, paused, rate_idx);
    end
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      et = (n % 4 == 0);
      n_chk++;
      if (tick !== et || btn_pressed !== 1'b0 ||
          rate_idx !== 2'd0 || paused !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release e%0d: got t=%b bp=%b r=%0d p=%b want t=%b 0 0 0",
                 n, tick, btn_pressed, rate_idx, paused, et);
      end
    end
  endtask

  task automatic test_bounce();
    logic et;
    sync_tick();
    for (int r = 1; r <= 45; r++) begin
      btn_in = (r <= 30) && (((r - 1) / 3) % 2 == 0);
      step();
      et = (r % 4 == 0);
      n_chk++;
      if (tick !== et || btn_pressed !== 1'b0 || rate_idx !== 2'd0) begin
        n_fail++;
        $display("FAIL bounce e%0d: got t=%b bp=%b r=%0d want t=%b bp=0 r=0",
                 r, tick, btn_pressed, rate_idx, et);
      end
    end
  endtask

  task automatic test_clean_press();
    logic       et, ep;
    logic [1:0] er;
    sync_tick();
    btn_in = 1'b1;
    for (int r = 1; r <= 40; r++) begin
      if (r == 21) btn_in = 1'b0;
      step();
      if (r < 11)       et = (r % 4 == 0);
      else if (r == 11) et = 1'b0;
      else              et = ((r - 11) % 8 == 0);
      ep = (r == 11);
      er = (r >= 11) ? 2'd1 : 2'd0;
      n_chk++;
      if (tick !== et || btn_pressed !== ep || rate_idx !== er) begin
        n_fail++;
        $display("FAIL clean_press e%0d: got t=%b bp=%b r=%0d want t=%b bp=%b r=%0d",
                 r, tick, btn_pressed, rate_idx, et, ep, er);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    logic       et, ep;
    logic [1:0] er;
    sync_tick();
    btn_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({tick, btn_pressed, paused, rate_idx} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got t=%b bp=%b p=%b r=%0d want 0",
               tick, btn_pressed, paused, rate_idx);
    end
    #1;
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      et = (n % 4 == 0) && (n < 11);
      ep = (n == 11);
      er = (n >= 11) ? 2'd1 : 2'd0;
      n_chk++;
      if (tick !== et || btn_pressed !== ep || rate_idx !== er) begin
        n_fail++;
        $display("FAIL reset_press e%0d: got t=%b bp=%b r=%0d want t=%b bp=%b r=%0d",
                 n, tick, btn_pressed, rate_idx, et, ep, er);
      end
    end
    btn_in = 1'b0;
    for (int i = 0; i < 20; i++) step();
  endtask

  task automatic test_rate_cycle();
    int         lat, cnt, p;
    logic [1:0] er;
    rst = 1'b1;
    btn_in = 1'b0;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      btn_in = 1'b1;
      for (lat = 1; lat <= 20; lat++) begin
        step();
        if (btn_pressed) break;
      end
      er = 2'(k + 1);
      p = 4 << er;
      n_chk++;
      if (lat !== 11 || rate_idx !== er) begin
        n_fail++;
        $display("FAIL press%0d: got lat=%0d r=%0d want lat=11 r=%0d",
                 k, lat, rate_idx, er);
      end
      btn_in = 1'b0;
      for (int j = 0; j < 2; j++) begin
        for (cnt = 1; cnt <= 80; cnt++) begin
          step();
          if (tick) break;
        end
        n_chk++;
        if (cnt !== p) begin
          n_fail++;
          $display("FAIL period%0d_%0d: got %0d want %0d", k, j, cnt, p);
        end
      end
    end
  endtask

`ifdef BLINK_RATE_PAUSE_EN
  task automatic test_pause();
    int         cnt;
    logic       ep, epa;
    logic [1:0] er;
    rst = 1'b1;
    btn_in = 1'b0;
    step();
    rst = 1'b0;
    step();
    btn_in = 1'b1;
    for (int r = 1; r <= 40; r++) begin
      step();
      ep  = (r == 11);
      epa = (r >= 35);
      n_chk++;
      if (btn_pressed !== ep || paused !== epa || (tick & paused) !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_on e%0d: got bp=%b p=%b t=%b want bp=%b p=%b t=0",
                 r, btn_pressed, paused, tick, ep, epa);
      end
    end
    btn_in = 1'b0;
    for (int r = 1; r <= 20; r++) begin
      step();
      n_chk++;
      if (paused !== 1'b1 || tick !== 1'b0 || btn_pressed !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold e%0d: got p=%b t=%b bp=%b want p=1 t=0 bp=0",
                 r, paused, tick, btn_pressed);
      end
    end
    btn_in = 1'b1;
    for (int r = 1; r <= 40; r++) begin
      step();
      ep  = (r == 11);
      epa = (r < 35);
      er  = (r >= 11) ? 2'd2 : 2'd1;
      n_chk++;
      if (btn_pressed !== ep || paused !== epa || rate_idx !== er ||
          (tick & paused) !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_off e%0d: got bp=%b p=%b r=%0d t=%b want bp=%b p=%b r=%0d",
                 r, btn_pressed, paused, rate_idx, tick, ep, epa, er);
      end
    end
    btn_in = 1'b0;
    sync_tick();
    for (int j = 0; j < 2; j++) begin
      for (cnt = 1; cnt <= 40; cnt++) begin
        step();
        if (tick) break;
      end
      n_chk++;
      if (cnt !== 16) begin
        n_fail++;
        $display("FAIL resume_period%0d: got %0d want 16", j, cnt);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_reset_mid_press();
    test_rate_cycle();
`ifdef BLINK_RATE_PAUSE_EN
    test_pause();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
